// File: rtl/simon_pkg.sv
// Shared types and LFSR helpers for the Simon game controller.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAUSE,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_INPUT,
    ST_WIN,
    ST_LOSE
  } simon_state_t;

  typedef logic [1:0] color_t;

  localparam logic [7:0] LFSR_RESET = 8'h01;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit Fibonacci LFSR with synchronous load and step; load has priority.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       step,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_RESET;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/simon_sequencer.sv
// Simon game controller: LFSR-regenerated playback, player input check, win/lose.
// Optional press echo on the LED during INPUT is enabled by defining SIMON_ECHO_EN.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned SHOW_TICKS    = 8,
  parameter int unsigned GAP_TICKS     = 4,
  parameter int unsigned TIMEOUT_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [7:0] seed,
  input  logic       btn_valid,
  input  logic [1:0] btn_color,
  output logic       led_on,
  output logic [1:0] led_color,
  output logic [7:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int unsigned CW = 16;

  simon_state_t state;
  logic [CW-1:0] cnt;
  logic [7:0]    idx;
  logic [7:0]    seed_r;
  logic [7:0]    seed_fix;
  logic [7:0]    lfsr_q;
  logic [7:0]    lfsr_val;
  logic [5:0]    lfsr_unused;
  color_t        cur_color;
  logic          lfsr_load, lfsr_step;
  logic          start_ok, pause_done, show_done, off_done, last_shown;
  logic          press_ok, press_last, at_max, timed_out;
`ifdef SIMON_ECHO_EN
  logic [CW-1:0] ecnt;
`endif

  assign {lfsr_unused, cur_color} = lfsr_q;

  assign seed_fix   = (seed == 8'h00) ? LFSR_RESET : seed;
  assign start_ok   = start && (state == ST_IDLE || state == ST_WIN || state == ST_LOSE);
  assign pause_done = (state == ST_PAUSE) && tick && (cnt == CW'(GAP_TICKS - 1));
  assign show_done  = (state == ST_SHOW_ON) && tick && (cnt == CW'(SHOW_TICKS - 1));
  assign off_done   = (state == ST_SHOW_OFF) && tick && (cnt == CW'(GAP_TICKS - 1));
  assign last_shown = off_done && (idx + 8'd1 == level);
  assign press_ok   = (state == ST_INPUT) && btn_valid && (btn_color == cur_color);
  assign press_last = press_ok && (idx + 8'd1 == level);
  assign at_max     = (level == 8'(MAX_LEN));
  assign timed_out  = (state == ST_INPUT) && !btn_valid && tick &&
                      (cnt == CW'(TIMEOUT_TICKS - 1));

  // The LFSR advances as SHOW_ON ends rather than as SHOW_OFF ends; it is not
  // observed in between, so the lit colour is simply lfsr[1:0] on SHOW_ON entry.
  assign lfsr_load = start_ok || last_shown || (press_last && !at_max);
  assign lfsr_step = show_done || (press_ok && !press_last);
  assign lfsr_val  = start_ok ? seed_fix : seed_r;

  simon_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (lfsr_val),
    .step     (lfsr_step),
    .q        (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      level     <= '0;
      seed_r    <= LFSR_RESET;
      led_on    <= 1'b0;
      led_color <= '0;
      busy      <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
`ifdef SIMON_ECHO_EN
      ecnt      <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (start_ok) begin
            state  <= ST_PAUSE;
            seed_r <= seed_fix;
            level  <= 8'd1;
            idx    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            win    <= 1'b0;
            lose   <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (pause_done) begin
            state     <= ST_SHOW_ON;
            cnt       <= '0;
            led_on    <= 1'b1;
            led_color <= cur_color;
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHOW_ON: begin
          if (show_done) begin
            state  <= ST_SHOW_OFF;
            cnt    <= '0;
            led_on <= 1'b0;
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHOW_OFF: begin
          if (off_done) begin
            cnt <= '0;
            if (last_shown) begin
              state <= ST_INPUT;
              idx   <= '0;
              busy  <= 1'b0;
            end else begin
              state     <= ST_SHOW_ON;
              idx       <= idx + 8'd1;
              led_on    <= 1'b1;
              led_color <= cur_color;
            end
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_INPUT: begin
          if (btn_valid) begin
            cnt <= '0;
            if (!press_ok) begin
              state  <= ST_LOSE;
              lose   <= 1'b1;
              led_on <= 1'b0;
            end else if (press_last) begin
              led_on <= 1'b0;
              if (at_max) begin
                state <= ST_WIN;
                win   <= 1'b1;
              end else begin
                state <= ST_PAUSE;
                level <= level + 8'd1;
                idx   <= '0;
                busy  <= 1'b1;
              end
            end else begin
              idx <= idx + 8'd1;
`ifdef SIMON_ECHO_EN
              led_on    <= 1'b1;
              led_color <= btn_color;
              ecnt      <= '0;
`endif
            end
          end else begin
            if (timed_out) begin
              state  <= ST_LOSE;
              lose   <= 1'b1;
              led_on <= 1'b0;
            end else if (tick) begin
              cnt <= cnt + 1'b1;
            end
`ifdef SIMON_ECHO_EN
            if (led_on && tick) begin
              if (ecnt == CW'(SHOW_TICKS - 1)) begin
                led_on <= 1'b0;
              end else begin
                ecnt <= ecnt + 1'b1;
              end
            end
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer: two instances (MAX_LEN 16 and 2) share stimulus.
module tb_simon_sequencer;

  logic       clk = 1'b0;
  logic       rst, tick, start, btn_valid;
  logic [7:0] seed;
  logic [1:0] btn_color;

  logic       led_on, busy, win, lose;
  logic [1:0] led_color;
  logic [7:0] level;
  logic       w_led_on, w_busy, w_win, w_lose;
  logic [1:0] w_led_color;
  logic [7:0] w_level;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_seq [0:3] = '{2'd1, 2'd2, 2'd0, 2'd0};

  always #5 clk = ~clk;

  simon_sequencer #(
    .MAX_LEN(16), .SHOW_TICKS(2), .GAP_TICKS(1), .TIMEOUT_TICKS(8)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .seed(seed),
    .btn_valid(btn_valid), .btn_color(btn_color),
    .led_on(led_on), .led_color(led_color), .level(level),
    .busy(busy), .win(win), .lose(lose)
  );

  simon_sequencer #(
    .MAX_LEN(2), .SHOW_TICKS(2), .GAP_TICKS(1), .TIMEOUT_TICKS(8)
  ) dut_w (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .seed(seed),
    .btn_valid(btn_valid), .btn_color(btn_color),
    .led_on(w_led_on), .led_color(w_led_color), .level(w_level),
    .busy(w_busy), .win(w_win), .lose(w_lose)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [1:0] c);
    btn_valid = 1'b1;
    btn_color = c;
    cyc();
    btn_valid = 1'b0;
  endtask

  // Called just after entering PAUSE; returns just after entering INPUT.
  task automatic playback(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      cyc();
      chk($sformatf("show%0d_%0d_on", n, i), led_on, 1'b1);
      chk($sformatf("show%0d_%0d_color", n, i), led_color, exp_seq[i]);
      cyc();
      chk($sformatf("show%0d_%0d_on2", n, i), led_on, 1'b1);
      cyc();
      chk($sformatf("show%0d_%0d_off", n, i), led_on, 1'b0);
      chk($sformatf("show%0d_%0d_busy", n, i), busy, 1'b1);
    end
    cyc();
    chk($sformatf("show%0d_input_busy", n), busy, 1'b0);
    chk($sformatf("show%0d_input_led", n), led_on, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; tick = 1'b1; start = 1'b0; btn_valid = 1'b0; btn_color = '0; seed = '0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_led_on", led_on, 1'b0);
    chk("rst_led_color", led_color, 2'd0);
    chk("rst_level", level, 8'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_win", win, 1'b0);
    chk("rst_lose", lose, 1'b0);
    chk("rst_w_all", {w_led_on, w_led_color, w_level, w_busy, w_win, w_lose}, '0);
    press(2'd0);
    chk("idle_press_level", level, 8'd0);
    chk("idle_press_flags", {busy, lose, win, led_on}, 4'b0000);

    // First rounds with seed 1
    seed = 8'h01; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_level", level, 8'd1);
    chk("start_dark", led_on, 1'b0);
    playback(1);
    press(2'd1);
    chk("r1_level", level, 8'd2);
    chk("r1_busy", busy, 1'b1);
    playback(2);
    press(2'd1);
    chk("r2_mid_level", level, 8'd2);
    chk("r2_mid_lose", lose, 1'b0);
    press(2'd2);
    chk("r2_level", level, 8'd3);
    chk("r2_busy", busy, 1'b1);
    chk("win_w", w_win, 1'b1);
    chk("win_w_level", w_level, 8'd2);
    chk("win_w_busy", w_busy, 1'b0);
    chk("win_w_lose", w_lose, 1'b0);

    // Wrong press
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_clears_win", w_win, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    playback(1);
    press(2'd3);
    chk("wrong_lose", lose, 1'b1);
    chk("wrong_level", level, 8'd1);
    chk("wrong_busy", busy, 1'b0);
    cyc();
    chk("lose_held", lose, 1'b1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_lose", lose, 1'b0);
    chk("restart_level", level, 8'd1);
    chk("restart_busy", busy, 1'b1);

    // start during SHOW_ON ignored
    cyc();
    chk("guard_on", led_on, 1'b1);
    seed = 8'h55; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("guard_still_on", led_on, 1'b1);
    chk("guard_color", led_color, 2'd1);
    chk("guard_level", level, 8'd1);
    cyc();
    chk("guard_off", led_on, 1'b0);
    cyc();
    chk("guard_input", busy, 1'b0);

    // Timeout
    repeat (7) cyc();
    chk("to_7_nolose", lose, 1'b0);
    cyc();
    chk("to_8_lose", lose, 1'b1);
    chk("to_level", level, 8'd1);

    // Press coinciding with the final timeout tick
    seed = 8'h01; start = 1'b1;
    cyc();
    start = 1'b0;
    playback(1);
    repeat (7) cyc();
    chk("late_nolose7", lose, 1'b0);
    press(2'd1);
    chk("late_press_lose", lose, 1'b0);
    chk("late_press_level", level, 8'd2);
    chk("late_press_busy", busy, 1'b1);

    // Seed zero behaves as seed 1
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    seed = 8'h00; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int unsigned lvl = 1; lvl <= 4; lvl++) begin
      playback(lvl);
      for (int unsigned i = 0; i < lvl; i++) press(exp_seq[i]);
      chk($sformatf("seed0_level_after_%0d", lvl), level, lvl + 1);
    end

    // Reset in the middle of SHOW_ON
    cyc();
    chk("midrst_on", led_on, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_led", led_on, 1'b0);
    chk("midrst_level", level, 8'd0);
    chk("midrst_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
